// File: rtl/bsg_demux_bitwise_stream.sv
// Streaming bitwise demux: splits each accepted word into two registered valid/ready channels by sel_i.
// Optional: define BSG_DEMUX_BITWISE_SKIP_EMPTY_EN to suppress loading a channel whose mask is all zeros.

module bsg_demux_bitwise_stream_chan #(
    parameter int width_p = 16,
    parameter int cnt_w_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               load_i,
    input  logic [width_p-1:0] data_i,
    input  logic [width_p-1:0] mask_i,
    input  logic               ready_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    output logic [width_p-1:0] mask_o,
    output logic [cnt_w_p-1:0] cnt_o
);
    localparam logic [cnt_w_p-1:0] one_lp = cnt_w_p'(1);

    logic deliver;
    assign deliver = v_o & ready_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v_o    <= 1'b0;
            data_o <= '0;
            mask_o <= '0;
            cnt_o  <= '0;
        end else begin
            // Reload wins over drain so a same-cycle deliver+accept keeps v_o high.
            if (load_i) begin
                v_o    <= 1'b1;
                data_o <= data_i;
                mask_o <= mask_i;
            end else if (deliver) begin
                v_o <= 1'b0;
            end
            if (deliver)
                cnt_o <= cnt_o + one_lp;
        end
    end
endmodule

module bsg_demux_bitwise_stream #(
    parameter int width_p = 16,
    parameter int cnt_w_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    input  logic [width_p-1:0] sel_i,
    output logic               ready_o,
    output logic               v0_o,
    output logic [width_p-1:0] data0_o,
    output logic [width_p-1:0] mask0_o,
    input  logic               ready0_i,
    output logic               v1_o,
    output logic [width_p-1:0] data1_o,
    output logic [width_p-1:0] mask1_o,
    input  logic               ready1_i,
    output logic [cnt_w_p-1:0] cnt0_o,
    output logic [cnt_w_p-1:0] cnt1_o
);
    logic [1:0]                  ch_ready, ch_can, ch_load, ch_v, ch_skip;
    logic [1:0][width_p-1:0]     ch_mask_in, ch_data, ch_mask;
    logic [1:0][cnt_w_p-1:0]     ch_cnt;
    logic                        accept;

    assign ch_ready      = {ready1_i, ready0_i};
    assign ch_mask_in[0] = ~sel_i;
    assign ch_mask_in[1] = sel_i;

    // ready_o depends only on channel state and consumer readies, never on v_i or data.
    assign ch_can  = ~ch_v | ch_ready;
    assign ready_o = &ch_can;
    assign accept  = v_i & ready_o;

`ifdef BSG_DEMUX_BITWISE_SKIP_EMPTY_EN
    assign ch_skip = {~|sel_i, &sel_i};
`else
    assign ch_skip = 2'b00;
`endif

    for (genvar k = 0; k < 2; k++) begin : g_ch
        assign ch_load[k] = accept & ~ch_skip[k];

        bsg_demux_bitwise_stream_chan #(
            .width_p (width_p),
            .cnt_w_p (cnt_w_p)
        ) u_chan (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .load_i    (ch_load[k]),
            .data_i    (data_i & ch_mask_in[k]),
            .mask_i    (ch_mask_in[k]),
            .ready_i   (ch_ready[k]),
            .v_o       (ch_v[k]),
            .data_o    (ch_data[k]),
            .mask_o    (ch_mask[k]),
            .cnt_o     (ch_cnt[k])
        );
    end

    assign v0_o    = ch_v[0];
    assign v1_o    = ch_v[1];
    assign data0_o = ch_data[0];
    assign data1_o = ch_data[1];
    assign mask0_o = ch_mask[0];
    assign mask1_o = ch_mask[1];
    assign cnt0_o  = ch_cnt[0];
    assign cnt1_o  = ch_cnt[1];
endmodule

// File: tb/tb_bsg_demux_bitwise_stream.sv
// Directed bench for bsg_demux_bitwise_stream; a second instance with cnt_w_p=3 covers counter wrap.

module tb_bsg_demux_bitwise_stream;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        v_i;
    logic [15:0] data_i, sel_i;
    logic        ready0, ready1;
    logic        ready_o, v0, v1;
    logic [15:0] data0, data1, mask0, mask1;
    logic [7:0]  cnt0, cnt1;
    logic        w_ready, w_v0, w_v1;
    logic [15:0] w_data0, w_data1, w_mask0, w_mask1;
    logic [2:0]  w_cnt0, w_cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bsg_demux_bitwise_stream #(.width_p(16), .cnt_w_p(8)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .data_i(data_i), .sel_i(sel_i),
        .ready_o(ready_o), .v0_o(v0), .data0_o(data0), .mask0_o(mask0), .ready0_i(ready0),
        .v1_o(v1), .data1_o(data1), .mask1_o(mask1), .ready1_i(ready1),
        .cnt0_o(cnt0), .cnt1_o(cnt1)
    );

    bsg_demux_bitwise_stream #(.width_p(16), .cnt_w_p(3)) dut_wrap (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .data_i(data_i), .sel_i(sel_i),
        .ready_o(w_ready), .v0_o(w_v0), .data0_o(w_data0), .mask0_o(w_mask0), .ready0_i(ready0),
        .v1_o(w_v1), .data1_o(w_data1), .mask1_o(w_mask1), .ready1_i(ready1),
        .cnt0_o(w_cnt0), .cnt1_o(w_cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    logic [15:0] d, s, pd, ps;

    initial begin
        reset_n = 1'b0; v_i = 1'b1; data_i = 16'hFFFF; sel_i = 16'h00FF;
        ready0 = 1'b1; ready1 = 1'b1;

        // Reset held with v_i=1
        repeat (3) @(negedge clk);
        chk("rst_v0", 32'(v0), 0);
        chk("rst_v1", 32'(v1), 0);
        chk("rst_cnt0", 32'(cnt0), 0);
        chk("rst_cnt1", 32'(cnt1), 0);
        chk("rst_data1", 32'(data1), 0);
        chk("rst_mask0", 32'(mask0), 0);

        // Split A5C3 by 00FF
        reset_n = 1'b1; data_i = 16'hA5C3; sel_i = 16'h00FF;
        #1 chk("split_ready", 32'(ready_o), 1);
        @(negedge clk);
        v_i = 1'b0;
        chk("split_v0", 32'(v0), 1);
        chk("split_v1", 32'(v1), 1);
        chk("split_data1", 32'(data1), 32'h00C3);
        chk("split_data0", 32'(data0), 32'hA500);
        chk("split_mask1", 32'(mask1), 32'h00FF);
        chk("split_mask0", 32'(mask0), 32'hFF00);
        chk("split_cnt0", 32'(cnt0), 0);
        @(negedge clk);
        chk("split_drain_v0", 32'(v0), 0);
        chk("split_drain_v1", 32'(v1), 0);
        chk("split_cnt0_1", 32'(cnt0), 1);
        chk("split_cnt1_1", 32'(cnt1), 1);

        // 20 back-to-back beats, full throughput
        pd = '0; ps = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("strm_v1", 32'(v1), 1);
                chk("strm_data1", 32'(data1), 32'(pd & ps));
                chk("strm_data0", 32'(data0), 32'(pd & ~ps));
                chk("strm_or", 32'(data0 | data1), 32'(pd));
            end
            d = 16'(16'h1111 * (i + 1) + 16'h0700);
            s = i[0] ? 16'h0FF0 : 16'hFF00;
            v_i = 1'b1; data_i = d; sel_i = s;
            #1 chk("strm_ready", 32'(ready_o), 1);
            pd = d; ps = s;
        end
        @(negedge clk);
        v_i = 1'b0;
        chk("strm_last_data1", 32'(data1), 32'(pd & ps));
        @(negedge clk);
        chk("strm_cnt0", 32'(cnt0), 21);
        chk("strm_cnt1", 32'(cnt1), 21);
        chk("strm_idle_v0", 32'(v0), 0);

        // Back-pressure on channel 1
        v_i = 1'b1; data_i = 16'h1234; sel_i = 16'h0F0F;
        @(negedge clk);
        ready1 = 1'b0; data_i = 16'hBEEF; sel_i = 16'hF0F0;
        #1 chk("bp_ready_first", 32'(ready_o), 0);
        repeat (4) begin
            @(negedge clk);
            chk("bp_ready", 32'(ready_o), 0);
            chk("bp_v0_idle", 32'(v0), 0);
            chk("bp_v1_held", 32'(v1), 1);
            chk("bp_data1_stable", 32'(data1), 32'h0204);
            chk("bp_cnt0", 32'(cnt0), 22);
            chk("bp_cnt1", 32'(cnt1), 21);
        end
        ready1 = 1'b1;
        #1 chk("bp_ready_release", 32'(ready_o), 1);
        @(negedge clk);
        v_i = 1'b0;
        chk("bp_v0_next", 32'(v0), 1);
        chk("bp_v1_next", 32'(v1), 1);
        chk("bp_data0_next", 32'(data0), 32'h0E0F);
        chk("bp_data1_next", 32'(data1), 32'hB0E0);
        chk("bp_cnt1_resume", 32'(cnt1), 22);
        @(negedge clk);
        chk("bp_cnt0_end", 32'(cnt0), 23);
        chk("bp_cnt1_end", 32'(cnt1), 23);

        // All-zero select
        v_i = 1'b1; data_i = 16'h5A5A; sel_i = 16'h0000;
        @(negedge clk);
        v_i = 1'b0;
        chk("zero_v0", 32'(v0), 1);
        chk("zero_data0", 32'(data0), 32'h5A5A);
`ifdef BSG_DEMUX_BITWISE_SKIP_EMPTY_EN
        chk("zero_v1_skip", 32'(v1), 0);
`else
        chk("zero_v1", 32'(v1), 1);
        chk("zero_data1", 32'(data1), 0);
`endif
        @(negedge clk);
        chk("zero_cnt0", 32'(cnt0), 24);
`ifdef BSG_DEMUX_BITWISE_SKIP_EMPTY_EN
        chk("zero_cnt1_skip", 32'(cnt1), 23);
`else
        chk("zero_cnt1", 32'(cnt1), 24);
`endif

        // Reset while a beat is held drops it immediately
        ready0 = 1'b0; v_i = 1'b1; data_i = 16'h3C3C; sel_i = 16'h00F0;
        @(negedge clk);
        v_i = 1'b0;
        chk("midrst_held", 32'(v0), 1);
        #2 reset_n = 1'b0;
        #1 chk("midrst_v0", 32'(v0), 0);
        chk("midrst_cnt0", 32'(cnt0), 0);
        ready0 = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;

        // Wrap: 9 channel-0 deliveries on the 3-bit counter instance
        for (int i = 0; i < 9; i++) begin
            v_i = 1'b1; data_i = 16'(i * 3 + 1); sel_i = 16'h8001;
            @(negedge clk);
        end
        v_i = 1'b0;
        @(negedge clk);
        chk("wrap_cnt0_w3", 32'(w_cnt0), 1);
        chk("wrap_cnt0_w8", 32'(cnt0), 9);
        chk("wrap_cnt1_w3", 32'(w_cnt1), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
